// File: rtl/aes_pkg.sv
// Shared AES types: the byte type and the substitution engine FSM states.
package aes_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of a counter that indexes 'passes' passes; never narrower than 1 bit.
  function automatic int pass_width(input int passes);
    return (passes > 1) ? $clog2(passes) : 1;
  endfunction

endpackage

// File: rtl/inv_sbox.sv
// AES inverse S-box (FIPS-197), one byte, purely combinational.
// Same storage layout and port shape as sbox.
module inv_sbox (
  input  logic [7:0] in_byte_i,
  output logic [7:0] out_byte_o
);

  localparam logic [2047:0] INV_TABLE = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign out_byte_o = INV_TABLE[{~in_byte_i, 3'b000} +: 8];

endmodule

// File: rtl/sbox.sv
// AES forward S-box (FIPS-197), one byte, purely combinational.
// The table is stored with entry 0 in the most significant byte, so entry e
// lives at bit offset 8*(255-e), which is {~e, 3'b000} for an 8-bit e.
module sbox (
  input  logic [7:0] in_byte_i,
  output logic [7:0] out_byte_o
);

  localparam logic [2047:0] FWD_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out_byte_o = FWD_TABLE[{~in_byte_i, 3'b000} +: 8];

endmodule

// File: rtl/sub_bytes_engine.sv
// Multi-pass AES SubBytes engine: a captured word of LANES bytes is pushed
// through SBOX_CNT shared S-boxes, SBOX_CNT bytes per cycle, over
// LANES/SBOX_CNT passes, then held in DONE until downstream takes it.
// Optional feature macro: SUB_BYTES_INV_EN adds inverse S-boxes selected by
// in_inv; without it in_inv is accepted but forward substitution is always used.
import aes_pkg::*;

module sub_bytes_engine #(
  parameter int LANES    = 16,
  parameter int SBOX_CNT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
  input  logic               in_inv,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic               busy
);

  localparam int PASSES = LANES / SBOX_CNT;
  localparam int SW     = 8 * SBOX_CNT;
  localparam int PW     = pass_width(PASSES);
  localparam logic [PW-1:0] LAST_PASS = PW'(PASSES - 1);

  state_e             state_q, state_d;
  logic [PW-1:0]      pass_q, pass_d;
  logic [8*LANES-1:0] word_q, word_d;
  logic [8*LANES-1:0] result_q, result_d;
  logic               inv_q, inv_d;
  logic [SW-1:0]      slice_in;
  logic [SW-1:0]      slice_out;

  // Pick the SBOX_CNT-byte slice of the captured word addressed by the pass counter.
  always_comb begin
    slice_in = '0;
    for (int p = 0; p < PASSES; p++) begin
      if (pass_q == PW'(p)) begin
        slice_in = word_q[p*SW +: SW];
      end
    end
  end

  for (genvar g = 0; g < SBOX_CNT; g++) begin : g_lane
    logic [7:0] fwd_byte;

    sbox u_sbox (
      .in_byte_i  (slice_in[8*g +: 8]),
      .out_byte_o (fwd_byte)
    );

`ifdef SUB_BYTES_INV_EN
    logic [7:0] inv_byte;

    inv_sbox u_inv_sbox (
      .in_byte_i  (slice_in[8*g +: 8]),
      .out_byte_o (inv_byte)
    );

    assign slice_out[8*g +: 8] = inv_q ? inv_byte : fwd_byte;
`else
    assign slice_out[8*g +: 8] = fwd_byte;
`endif
  end

`ifndef SUB_BYTES_INV_EN
  // The captured mode has no consumer when the inverse tables are absent.
  logic unused_inv;
  assign unused_inv = inv_q;
`endif

  // Next-state, datapath update and handshake outputs; a transfer overrides
  // whatever the current state would otherwise do and restarts at pass 0.
  always_comb begin
    state_d   = state_q;
    pass_d    = pass_q;
    word_d    = word_q;
    result_d  = result_q;
    inv_d     = inv_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
      end
      RUN: begin
        for (int p = 0; p < PASSES; p++) begin
          if (pass_q == PW'(p)) begin
            result_d[p*SW +: SW] = slice_out;
          end
        end
        if (pass_q == LAST_PASS) begin
          state_d = DONE;
        end else begin
          pass_d = pass_q + PW'(1);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (in_valid && in_ready) begin
      state_d = RUN;
      pass_d  = '0;
      word_d  = in_data;
      inv_d   = in_inv;
    end
  end

  assign out_data = result_q;

  // State and datapath registers; reset aborts any word in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pass_q   <= '0;
      word_q   <= '0;
      result_q <= '0;
      inv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pass_q   <= pass_d;
      word_q   <= word_d;
      result_q <= result_d;
      inv_q    <= inv_d;
    end
  end

endmodule

// File: doc/sub_bytes_engine.md
SUB_BYTES_ENGINE -- requirements
Module: sub_bytes_engine

Interface
REQ-001 The block SHALL have parameter LANES, default 16, meaning the number of bytes per data word; legal values are 4 and 16.
REQ-002 The block SHALL have parameter SBOX_CNT, default 4, meaning the number of S-box instances used per cycle; it must divide LANES.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the input word is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the engine accepts a word.
REQ-007 The block SHALL have port in_data, input, 8*LANES bits: the input word; byte i is bits [8i+7:8i].
REQ-008 The block SHALL have port in_inv, input, 1 bit: 1 selects inverse SubBytes for this word.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the result word is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-011 The block SHALL have port out_data, output, 8*LANES bits: the substituted word, with the same byte ordering as in_data.
REQ-012 The block SHALL have port busy, output, 1 bit: high while state is not IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE, where PASSES = LANES/SBOX_CNT.
REQ-014 A transfer SHALL occur when in_valid and in_ready are both high on a clock edge; in_data and in_inv are then captured and the pass counter is cleared; the FSM goes IDLE->RUN or DONE->RUN.
REQ-015 In RUN, pass k (k = 0..PASSES-1) SHALL substitute bytes k*SBOX_CNT .. k*SBOX_CNT+SBOX_CNT-1 of the captured word and register them into the result.
REQ-016 The FSM SHALL go RUN->DONE on the edge that completes pass PASSES-1.
REQ-017 out_valid SHALL rise exactly PASSES cycles after the accepting edge (latency 4 for the default parameters).
REQ-018 out_valid SHALL be high only in DONE; out_data SHALL be stable while out_valid is high and out_ready is low.
REQ-019 in_ready SHALL equal (state==IDLE) or (state==DONE and out_ready), which allows back-to-back words with zero bubble on the output side.
REQ-020 In DONE, out_ready high with no new transfer SHALL cause DONE->IDLE.
REQ-021 In DONE, out_ready high together with a transfer SHALL cause DONE->RUN and capture the new word.
REQ-022 in_valid SHALL be ignored in RUN, and in DONE while out_ready is low.
REQ-023 When PASSES==1, RUN SHALL last one cycle, so the latency is 1.
REQ-024 Each byte substitution SHALL be pure table lookup per FIPS-197; there is no arithmetic and no carry between bytes.

Reset
REQ-025 On rst high at a clock edge, the FSM SHALL go to IDLE, and the pass counter, captured word, result and captured mode SHALL clear to 0.
REQ-026 Reset values SHALL be out_valid=0, busy=0, out_data=0, and in_ready=1 (because IDLE).
REQ-027 Reset asserted during RUN or DONE SHALL abort the word with no output beat; rst has priority over a simultaneous transfer.

Configuration
REQ-028 With macro SUB_BYTES_INV_EN defined, in_inv=1 SHALL select the inverse S-box for all bytes of the captured word.
REQ-029 Without SUB_BYTES_INV_EN, the in_inv port SHALL remain present but be ignored, forward substitution SHALL always be used, and no inverse table SHALL be synthesised.

Structure
REQ-030 The package aes_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and the byte typedef.
REQ-031 The forward lookup SHALL reuse the existing sbox module, with SBOX_CNT instances.
REQ-032 The single new sub-module SHALL be inv_sbox, an 8-bit combinational inverse table with the same port shape as sbox, instantiated SBOX_CNT times only under SUB_BYTES_INV_EN.

Verification
REQ-033 With LANES=16, SBOX_CNT=4, in_data bytes 0..15 = 00..0f and in_inv=0, the bench SHALL see out_data bytes 63 7c 77 7b f2 6b 6f c5 30 01 67 2b fe d7 ab 76, with out_valid exactly 4 cycles after acceptance.
REQ-034 With SUB_BYTES_INV_EN defined, all bytes = 63 and in_inv=1, the bench SHALL see all output bytes = 00; and all bytes = 16 with in_inv=1 SHALL give all ff.
REQ-035 With out_ready held low for 5 cycles in DONE, out_data SHALL stay constant and in_ready=0; after out_ready rises with in_valid=1 (bytes 53), the new word SHALL be accepted that cycle and yield bytes ed 4 cycles later.
REQ-036 With rst asserted in the second RUN cycle, the next cycle SHALL show busy=0, out_valid=0, out_data=0 and in_ready=1, and no output beat SHALL ever appear for that word.
REQ-037 With LANES=4, SBOX_CNT=4 and word 0x00000052, the output SHALL be 0x63636300 with latency 1.
REQ-038 Without SUB_BYTES_INV_EN, all bytes = 00 with in_inv=1 SHALL give all 63.
